rename_regfile: RTL and testbench



---
 rtl/rename_regfile.sv | 110 +++++++++++
 tb/tb_rename_regfile.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rename_regfile.sv
// Architectural register file with per-register ROB rename tags.
// Dispatch reads values or pending tags; ROB commits write results and release renames.
module rename_regfile #(
    parameter int REG_NUM = 32,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clear,
    input  logic              id_valid,
    input  logic [4:0]        id_dest_reg,
    input  logic [TAG_W-1:0]  id_tag,
    input  logic [4:0]        rs1_addr,
    input  logic [4:0]        rs2_addr,
    output logic              rs1_busy,
    output logic [TAG_W-1:0]  rs1_tag,
    output logic [DATA_W-1:0] rs1_data,
    output logic              rs2_busy,
    output logic [TAG_W-1:0]  rs2_tag,
    output logic [DATA_W-1:0] rs2_data,
    input  logic              cm_valid,
    input  logic [4:0]        cm_reg,
    input  logic [TAG_W-1:0]  cm_tag,
    input  logic [DATA_W-1:0] cm_data
);

    typedef struct packed {
        logic              busy;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } rd_t;

    logic [DATA_W-1:0] data_q [REG_NUM];
    logic [TAG_W-1:0]  tag_q  [REG_NUM];
    logic [REG_NUM-1:0] busy_q;

    logic cm_release;
    logic cm_write;
    logic id_write;

    assign cm_write   = cm_valid && (cm_reg != 5'd0);
    assign cm_release = cm_write && busy_q[cm_reg] && (tag_q[cm_reg] == cm_tag);
    assign id_write   = id_valid && (id_dest_reg != 5'd0) && !clear;

    // A same-cycle rename is applied after the release, so the new owner wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            for (int i = 0; i < REG_NUM; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else if (rdy) begin
            if (clear) begin
                busy_q <= '0;
            end else if (cm_release) begin
                busy_q[cm_reg] <= 1'b0;
            end
            if (cm_write) begin
                data_q[cm_reg] <= cm_data;
            end
            if (id_write) begin
                busy_q[id_dest_reg] <= 1'b1;
                tag_q[id_dest_reg]  <= id_tag;
            end
        end
    end

    // Commit bypass lets dispatch pick up a value retiring this very cycle.
    function automatic rd_t lookup(
        input logic [4:0]        addr,
        input logic [DATA_W-1:0] st_data,
        input logic              st_busy,
        input logic [TAG_W-1:0]  st_tag,
        input logic              c_valid,
        input logic [4:0]        c_reg,
        input logic [TAG_W-1:0]  c_tag,
        input logic [DATA_W-1:0] c_data
    );
        rd_t r;
        r.busy = st_busy;
        r.tag  = st_tag;
        r.data = st_data;
        if (addr == 5'd0) begin
            r = '0;
        end else if (c_valid && (c_reg == addr) && st_busy && (st_tag == c_tag)) begin
            r.busy = 1'b0;
            r.data = c_data;
        end
        return r;
    endfunction

    rd_t rd1;
    rd_t rd2;

    assign rd1 = lookup(rs1_addr, data_q[rs1_addr], busy_q[rs1_addr], tag_q[rs1_addr],
                        cm_valid, cm_reg, cm_tag, cm_data);
    assign rd2 = lookup(rs2_addr, data_q[rs2_addr], busy_q[rs2_addr], tag_q[rs2_addr],
                        cm_valid, cm_reg, cm_tag, cm_data);

    assign rs1_busy = rd1.busy;
    assign rs1_tag  = rd1.tag;
    assign rs1_data = rd1.data;
    assign rs2_busy = rd2.busy;
    assign rs2_tag  = rd2.tag;
    assign rs2_data = rd2.data;

endmodule

// File: tb/tb_rename_regfile.sv
// Self-checking bench for rename_regfile: directed vector table followed by
// randomized traffic checked against a per-register behavioural model.
module tb_rename_regfile;

    localparam int TAG_W  = 4;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst, rdy, clear, id_valid, cm_valid;
    logic [4:0]        id_dest_reg, rs1_addr, rs2_addr, cm_reg;
    logic [TAG_W-1:0]  id_tag, cm_tag, rs1_tag, rs2_tag;
    logic [DATA_W-1:0] cm_data, rs1_data, rs2_data;
    logic              rs1_busy, rs2_busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rename_regfile dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .id_valid(id_valid), .id_dest_reg(id_dest_reg), .id_tag(id_tag),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_busy(rs1_busy), .rs1_tag(rs1_tag), .rs1_data(rs1_data),
        .rs2_busy(rs2_busy), .rs2_tag(rs2_tag), .rs2_data(rs2_data),
        .cm_valid(cm_valid), .cm_reg(cm_reg), .cm_tag(cm_tag), .cm_data(cm_data)
    );

    typedef struct {
        bit              chk;
        bit              rst, rdy, clr;
        bit              idv;
        bit [4:0]        idr;
        bit [TAG_W-1:0]  idt;
        bit [4:0]        a1, a2;
        bit              cmv;
        bit [4:0]        cmr;
        bit [TAG_W-1:0]  cmt;
        bit [DATA_W-1:0] cmd;
        bit              e1b;
        bit [TAG_W-1:0]  e1t;
        bit [DATA_W-1:0] e1d;
        bit              e2b;
        bit [TAG_W-1:0]  e2t;
        bit [DATA_W-1:0] e2d;
    } vec_t;

    vec_t vecs[$];

    // Reference state: what each architectural register holds per the rules.
    bit [DATA_W-1:0] m_data [32];
    bit              m_busy [32];
    bit [TAG_W-1:0]  m_tag  [32];

    function automatic void add_vec(
        bit chk, bit r, bit rd, bit clr,
        bit idv, bit [4:0] idr, bit [TAG_W-1:0] idt,
        bit [4:0] a1, bit [4:0] a2,
        bit cmv, bit [4:0] cmr, bit [TAG_W-1:0] cmt, bit [DATA_W-1:0] cmd,
        bit e1b, bit [TAG_W-1:0] e1t, bit [DATA_W-1:0] e1d,
        bit e2b, bit [TAG_W-1:0] e2t, bit [DATA_W-1:0] e2d);
        vec_t v;
        v.chk = chk; v.rst = r; v.rdy = rd; v.clr = clr;
        v.idv = idv; v.idr = idr; v.idt = idt;
        v.a1 = a1; v.a2 = a2;
        v.cmv = cmv; v.cmr = cmr; v.cmt = cmt; v.cmd = cmd;
        v.e1b = e1b; v.e1t = e1t; v.e1d = e1d;
        v.e2b = e2b; v.e2t = e2t; v.e2d = e2d;
        vecs.push_back(v);
    endfunction

    function automatic void model_read(input vec_t v, input bit [4:0] a,
                                       output bit b, output bit [TAG_W-1:0] t,
                                       output bit [DATA_W-1:0] d);
        b = 0; t = '0; d = '0;
        if (a != 0) begin
            b = m_busy[a]; t = m_tag[a]; d = m_data[a];
            if (v.cmv && v.cmr == a && m_busy[a] && m_tag[a] == v.cmt) begin
                b = 0; d = v.cmd;
            end
        end
    endfunction

    function automatic void model_step(input vec_t v);
        if (v.rst) begin
            for (int i = 0; i < 32; i++) begin
                m_data[i] = '0; m_busy[i] = 0; m_tag[i] = '0;
            end
        end else if (v.rdy) begin
            if (v.cmv && v.cmr != 0) begin
                if (m_busy[v.cmr] && m_tag[v.cmr] == v.cmt) m_busy[v.cmr] = 0;
                m_data[v.cmr] = v.cmd;
            end
            if (v.clr) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 0;
            end else if (v.idv && v.idr != 0) begin
                m_busy[v.idr] = 1; m_tag[v.idr] = v.idt;
            end
        end
    endfunction

    task automatic checkOutput(input string name, input bit eb, input bit [TAG_W-1:0] et,
                               input bit [DATA_W-1:0] ed, input logic ab,
                               input logic [TAG_W-1:0] at, input logic [DATA_W-1:0] ad);
        total++;
        if (ab !== eb) begin
            bad++;
            $display("[TB] FAIL %s busy: got %b want %b", name, ab, eb);
        end
        total++;
        if (ad !== ed) begin
            bad++;
            $display("[TB] FAIL %s data: got %h want %h", name, ad, ed);
        end
        if (eb) begin
            total++;
            if (at !== et) begin
                bad++;
                $display("[TB] FAIL %s tag: got %0d want %0d", name, at, et);
            end
        end
    endtask

    task automatic applyStimulus(input vec_t v, input string name);
        @(negedge clk);
        rst = v.rst; rdy = v.rdy; clear = v.clr;
        id_valid = v.idv; id_dest_reg = v.idr; id_tag = v.idt;
        rs1_addr = v.a1; rs2_addr = v.a2;
        cm_valid = v.cmv; cm_reg = v.cmr; cm_tag = v.cmt; cm_data = v.cmd;
        #1;
        if (v.chk) begin
            checkOutput({name, " rs1"}, v.e1b, v.e1t, v.e1d, rs1_busy, rs1_tag, rs1_data);
            checkOutput({name, " rs2"}, v.e2b, v.e2t, v.e2d, rs2_busy, rs2_tag, rs2_data);
        end
        model_step(v);
    endtask

    initial begin
        vec_t v;
        rst = 1; rdy = 1; clear = 0; id_valid = 0; id_dest_reg = 0; id_tag = 0;
        rs1_addr = 0; rs2_addr = 0; cm_valid = 0; cm_reg = 0; cm_tag = 0; cm_data = 0;

        //      chk rst rdy clr idv idr idt a1 a2 cmv cmr cmt cmd           e1b e1t e1d           e2b e2t e2d
        add_vec(0, 1, 1, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0,            0, 0, 0,            0, 0, 0);
        add_vec(0, 1, 1, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0,            0, 0, 0,            0, 0, 0);
        add_vec(1, 0, 1, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0,            0, 0, 0,            0, 0, 0);
        add_vec(1, 0, 1, 0, 1, 5, 3, 5, 0, 0, 0, 0, 0,            0, 0, 0,            0, 0, 0);
        add_vec(1, 0, 1, 0, 0, 0, 0, 5, 5, 0, 0, 0, 0,            1, 3, 0,            1, 3, 0);
        add_vec(1, 0, 1, 0, 0, 0, 0, 5, 0, 1, 5, 3, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 0, 0, 0);
        add_vec(1, 0, 1, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0,            0, 0, 32'hDEADBEEF, 0, 0, 0);
        add_vec(1, 0, 1, 0, 1, 7, 2, 7, 0, 0, 0, 0, 0,            0, 0, 0,            0, 0, 0);
        add_vec(1, 0, 1, 0, 1, 7, 9, 7, 0, 0, 0, 0, 0,            1, 2, 0,            0, 0, 0);
        add_vec(1, 0, 1, 0, 0, 0, 0, 7, 7, 1, 7, 2, 32'h11,       1, 9, 0,            1, 9, 0);
        add_vec(1, 0, 1, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0,            1, 9, 32'h11,       0, 0, 0);
        add_vec(1, 0, 1, 0, 0, 0, 0, 7, 0, 1, 7, 9, 32'h22,       0, 0, 32'h22,       0, 0, 0);
        add_vec(1, 0, 1, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0,            0, 0, 32'h22,       0, 0, 0);
        add_vec(1, 0, 1, 0, 1, 4, 1, 4, 0, 0, 0, 0, 0,            0, 0, 0,            0, 0, 0);
        add_vec(1, 0, 1, 0, 1, 4, 6, 4, 0, 1, 4, 1, 32'h55,       0, 0, 32'h55,       0, 0, 0);
        add_vec(1, 0, 1, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0,            1, 6, 32'h55,       0, 0, 0);
        add_vec(1, 0, 1, 0, 1, 1, 4, 1, 0, 0, 0, 0, 0,            0, 0, 0,            0, 0, 0);
        add_vec(1, 0, 1, 0, 1, 2, 5, 1, 2, 0, 0, 0, 0,            1, 4, 0,            0, 0, 0);
        add_vec(1, 0, 1, 1, 1, 3, 7, 1, 2, 1, 1, 4, 32'h80,       0, 0, 32'h80,       1, 5, 0);
        add_vec(1, 0, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0,            0, 0, 32'h80,       0, 0, 0);
        add_vec(1, 0, 1, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0,            0, 0, 0,            0, 0, 0);
        add_vec(1, 0, 1, 0, 1, 0, 2, 0, 0, 1, 0, 2, 32'h99,       0, 0, 0,            0, 0, 0);
        add_vec(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0,            0, 0, 0);
        add_vec(1, 0, 0, 0, 1, 6, 8, 6, 0, 1, 6, 8, 32'h77,       0, 0, 0,            0, 0, 0);
        add_vec(1, 0, 1, 0, 0, 0, 0, 6, 0, 0, 0, 0, 0,            0, 0, 0,            0, 0, 0);
        add_vec(1, 0, 1, 0, 1, 9, 3, 9, 0, 0, 0, 0, 0,            0, 0, 0,            0, 0, 0);
        add_vec(1, 1, 1, 0, 1, 9, 4, 9, 5, 1, 9, 3, 32'h5,        0, 0, 32'h5,        0, 0, 32'hDEADBEEF);
        add_vec(1, 0, 1, 0, 0, 0, 0, 9, 5, 0, 0, 0, 0,            0, 0, 0,            0, 0, 0);

        foreach (vecs[i]) applyStimulus(vecs[i], $sformatf("vec%0d", i));

        // Random traffic over a few registers so renames and commits collide often.
        for (int n = 0; n < 600; n++) begin
            v.chk = 1;
            v.rst = ($urandom_range(0, 99) == 0);
            v.rdy = ($urandom_range(0, 9) != 0);
            v.clr = ($urandom_range(0, 15) == 0);
            v.idv = $urandom_range(0, 1);
            v.idr = 5'($urandom_range(0, 7));
            v.idt = TAG_W'($urandom_range(0, 15));
            v.a1  = 5'($urandom_range(0, 7));
            v.a2  = 5'($urandom_range(0, 7));
            v.cmv = $urandom_range(0, 1);
            v.cmr = 5'($urandom_range(0, 7));
            v.cmt = ($urandom_range(0, 3) != 0) ? m_tag[v.cmr] : TAG_W'($urandom_range(0, 15));
            v.cmd = $urandom;
            model_read(v, v.a1, v.e1b, v.e1t, v.e1d);
            model_read(v, v.a2, v.e2b, v.e2t, v.e2d);
            applyStimulus(v, $sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
